freq_div_prog: RTL and testbench
================================

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 Parameter CNT_W, default 8, width of the period counter and of cfg_div.
REQ-002 Parameter DEF_DIV, default 6, divisor in force after reset; legal range 2..2^CNT_W-1.
REQ-003 Parameter BURST_W, default 8, width of the burst-length field.
REQ-004 Parameter DEF_BURST, default 4, burst length in force after reset; must be at least 1.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset_n  in  1  synchronous reset, active-low.
REQ-007 start  in  1  start request, sampled while the block is idle.
REQ-008 stop  in  1  graceful stop request.
REQ-009 cfg_valid  in  1  configuration offer.
REQ-010 cfg_ready  out  1  configuration accept capability.
REQ-011 cfg_div  in  CNT_W  requested divisor.
REQ-012 cfg_mode  in  1  0 = continuous, 1 = burst.
REQ-013 cfg_burst  in  BURST_W  number of periods per burst.
REQ-014 cfg_err  out  1  one-cycle pulse when a config is rejected.
REQ-015 clk_div  out  1  divided clock.
REQ-016 tick  out  1  one-cycle pulse on the last cycle of each period.
REQ-017 busy  out  1  high while in RUN.
REQ-018 done  out  1  one-cycle pulse when a burst completes.

Function
REQ-019 The block SHALL have two states: IDLE and RUN. It SHALL hold active registers div_act, mode_act and burst_act, plus a shadow copy with a pend flag.
REQ-020 In RUN, cnt SHALL count 0..div_act-1 and then wrap to 0. In IDLE, cnt SHALL be held at 0.
REQ-021 clk_div SHALL equal busy AND (cnt >= div_act>>1). For example, div 6 gives 3 cycles low and 3 high; div 5 gives 2 low and 3 high.
REQ-022 tick SHALL equal busy AND (cnt == div_act-1); it is combinational from registered state.
REQ-023 cfg_ready SHALL equal NOT pend.
REQ-024 A transfer occurs when cfg_valid AND cfg_ready are both high.
  - If cfg_div < 2, or cfg_burst == 0 while cfg_mode == 1: cfg_err SHALL pulse on the next cycle and the shadow SHALL be unchanged.
  - Otherwise: the shadow SHALL load cfg_div, cfg_mode and cfg_burst, and pend SHALL be set.
REQ-025 Applying the shadow to the active registers and clearing pend:
  - in IDLE, on the edge following acceptance;
  - in RUN, on the wrap edge (tick high); the new period SHALL use the new div_act;
  - a config accepted on a tick cycle SHALL apply at the next wrap, not the current one.
REQ-026 IDLE to RUN: start high and stop low; cnt SHALL start at 0 on the next cycle and the burst counter SHALL clear. Start SHALL be ignored in RUN.
REQ-027 Stop SHALL set stop_pend. On the next wrap the block SHALL go to IDLE and clear stop_pend. A period is never truncated.
REQ-028 Stop and start together in IDLE: stop SHALL win and the block SHALL remain in IDLE.
REQ-029 In mode 1, each wrap SHALL increment the burst counter. The wrap that completes burst_act periods SHALL:
  - move the block to IDLE;
  - pulse done on the following cycle.
REQ-030 In mode 0, done SHALL never assert.
REQ-031 A stop that ends a burst early SHALL NOT pulse done.
REQ-032 Stop in IDLE SHALL be ignored and SHALL NOT be retained.
REQ-033 Counter comparisons SHALL be evaluated at CNT_W width, so a divisor of 2^CNT_W-1 is supported without overflow.

Reset
REQ-034 While reset_n is low at a clock edge, the next state SHALL be:
  - state IDLE, cnt 0;
  - div_act = DEF_DIV, mode_act = 0, burst_act = DEF_BURST;
  - pend 0, stop_pend 0, burst counter 0.
REQ-035 Output values under reset SHALL be: clk_div 0, tick 0, busy 0, done 0, cfg_err 0, cfg_ready 1.
REQ-036 A reset asserted mid-operation SHALL discard any pending shadow or stop, with no done or cfg_err pulse.

Verification
REQ-037 Reset, then start: busy rises 1 cycle later; clk_div pattern is 000111 repeating; tick pulses every 6 cycles.
REQ-038 In RUN with div 6, accept cfg_div 5 mid-period: cfg_ready drops; the current period completes at 6 cycles; subsequent periods are 5 cycles with pattern 00111; cfg_ready returns high on the apply edge.
REQ-039 Offer cfg_div 1, then cfg_mode 1 with cfg_burst 0: cfg_err pulses each time; the active divisor stays 6; a following good config is accepted.
REQ-040 Mode 1, burst 3, div 4, start: exactly 3 ticks spaced 4 cycles apart; busy lasts 12 cycles; done pulses once, 1 cycle after the 3rd tick.
REQ-041 Stop asserted at cnt 1 of div 6: 4 further cycles in RUN, then IDLE; clk_div low; no done pulse; start together with stop in IDLE leaves busy at 0.
REQ-042 reset_n low mid-burst with a config pending: all outputs at reset values next cycle; cfg_ready 1; a later start runs with div 6 in mode 0.

Source files
------------

// File: rtl/freq_div_prog_if.sv
// Control, configuration and output bundle of the programmable clock divider.
interface freq_div_prog_if #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BURST_W = 8
);
    logic               start;
    logic               stop;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic               cfg_mode;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_err;
    logic               clk_div;
    logic               tick;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, cfg_valid, cfg_div, cfg_mode, cfg_burst,
        input  cfg_ready, cfg_err, clk_div, tick, busy, done
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div, cfg_mode, cfg_burst,
        output cfg_ready, cfg_err, clk_div, tick, busy, done
    );
endinterface

// File: rtl/freq_div_prog.sv
// Programmable clock divider with continuous/burst modes, shadowed configuration
// applied on period boundaries, and graceful stop.
module freq_div_prog #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DEF_DIV   = 6,
    parameter int unsigned BURST_W   = 8,
    parameter int unsigned DEF_BURST = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    freq_div_prog_if.slave bus
);
    localparam int unsigned BC_W = BURST_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0]   div;
        logic               mode;
        logic [BURST_W-1:0] burst;
    } cfg_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cfg_t               act_q, act_d;
    cfg_t               shd_q, shd_d;
    logic               pend_q, pend_d;
    logic               stop_pend_q, stop_pend_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               busy_c;
    logic               tick_c;
    logic               xfer_c;
    logic               cfg_bad_c;
    logic               burst_last_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            act_q.div   <= CNT_W'(DEF_DIV);
            act_q.mode  <= 1'b0;
            act_q.burst <= BURST_W'(DEF_BURST);
            shd_q.div   <= CNT_W'(DEF_DIV);
            shd_q.mode  <= 1'b0;
            shd_q.burst <= BURST_W'(DEF_BURST);
            pend_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            burst_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            shd_q       <= shd_d;
            pend_q      <= pend_d;
            stop_pend_q <= stop_pend_d;
            burst_cnt_q <= burst_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Decodes of registered state and the config handshake.
    always_comb begin
        busy_c       = (state_q == ST_RUN);
        tick_c       = busy_c && (cnt_q == (act_q.div - CNT_W'(1)));
        xfer_c       = bus.cfg_valid && !pend_q;
        cfg_bad_c    = (bus.cfg_div < CNT_W'(2)) ||
                       (bus.cfg_mode && (bus.cfg_burst == '0));
        burst_last_c = (({1'b0, burst_cnt_q} + BC_W'(1)) >= {1'b0, act_q.burst});
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        shd_d       = shd_q;
        pend_d      = pend_q;
        stop_pend_d = stop_pend_q;
        burst_cnt_d = burst_cnt_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        // Shadow load; xfer implies no apply can clear pend in the same cycle.
        if (xfer_c) begin
            if (cfg_bad_c) begin
                cfg_err_d = 1'b1;
            end else begin
                shd_d.div   = bus.cfg_div;
                shd_d.mode  = bus.cfg_mode;
                shd_d.burst = bus.cfg_burst;
                pend_d      = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                stop_pend_d = 1'b0;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
                if (bus.start && !bus.stop) begin
                    state_d     = ST_RUN;
                    burst_cnt_d = '0;
                end
            end
            ST_RUN: begin
                stop_pend_d = stop_pend_q || bus.stop;
                if (tick_c) begin
                    // Wrap: the finishing period is judged on the old settings.
                    cnt_d = '0;
                    if (pend_q) begin
                        act_d  = shd_q;
                        pend_d = 1'b0;
                    end
                    if (act_q.mode) begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                    if (act_q.mode && burst_last_c) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (stop_pend_q || bus.stop) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.tick      = tick_c;
    assign bus.clk_div   = busy_c && (cnt_q >= (act_q.div >> 1));
    assign bus.cfg_ready = !pend_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Randomized and directed bench for freq_div_prog against a cycle-level behavioural model.
module tb_freq_div_prog;
    logic clk;
    logic reset_n;

    freq_div_prog_if #(.CNT_W(8), .BURST_W(8)) bus ();

    freq_div_prog #(
        .CNT_W(8), .DEF_DIV(6), .BURST_W(8), .DEF_BURST(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: running flag, position in period, active/shadow settings.
    int m_run = 0, m_cnt = 0, m_div = 6, m_mode = 0, m_burst = 4;
    int s_div = 6, s_mode = 0, s_burst = 4;
    int m_pend = 0, m_stop = 0, m_periods = 0, m_done = 0, m_err = 0;
    int t_wrap, t_acc, t_bad, t_fin;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_run = 0; m_cnt = 0; m_div = 6; m_mode = 0; m_burst = 4;
            m_pend = 0; m_stop = 0; m_periods = 0; m_done = 0; m_err = 0;
        end else begin
            t_wrap = (m_run != 0) && (m_cnt == m_div - 1);
            t_acc  = bus.cfg_valid && (m_pend == 0);
            t_bad  = t_acc && ((int'(bus.cfg_div) < 2) || (bus.cfg_mode && int'(bus.cfg_burst) == 0));
            m_err  = t_bad;
            m_done = 0;
            if (m_run == 0) begin
                if (m_pend != 0) begin
                    m_div = s_div; m_mode = s_mode; m_burst = s_burst; m_pend = 0;
                end
                m_stop = 0;
                if (bus.start && !bus.stop) begin
                    m_run = 1; m_cnt = 0; m_periods = 0;
                end
            end else if (t_wrap != 0) begin
                t_fin = (m_mode != 0) && (m_periods + 1 >= m_burst);
                if (m_mode != 0) m_periods++;
                if (t_fin != 0) m_done = 1;
                if ((t_fin != 0) || (m_stop != 0) || bus.stop) begin
                    m_run = 0; m_stop = 0;
                end
                m_cnt = 0;
                if (m_pend != 0) begin
                    m_div = s_div; m_mode = s_mode; m_burst = s_burst; m_pend = 0;
                end
            end else begin
                m_cnt++;
                if (bus.stop) m_stop = 1;
            end
            if ((t_acc != 0) && (t_bad == 0)) begin
                s_div = int'(bus.cfg_div); s_mode = int'(bus.cfg_mode);
                s_burst = int'(bus.cfg_burst); m_pend = 1;
            end
        end
    end

    function automatic logic [5:0] model_outs();
        logic r;
        r = (m_run != 0);
        return {r && (m_cnt >= m_div / 2), r && (m_cnt == m_div - 1), r,
                (m_done != 0), (m_err != 0), (m_pend == 0)};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on)
            check("cycle_outputs",
                  {26'd0, bus.clk_div, bus.tick, bus.busy, bus.done, bus.cfg_err, bus.cfg_ready},
                  {26'd0, model_outs()});
    end

    task automatic set_cfg(input bit v, input int d, input bit m, input int b);
        bus.cfg_valid = v;
        bus.cfg_div   = 8'(d);
        bus.cfg_mode  = m;
        bus.cfg_burst = 8'(b);
    endtask

    // Period between two consecutive ticks, plus clk_div-high cycles in that period.
    task automatic measure_period(output int per, output int highs);
        int guard;
        per = -1; highs = 0; guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.tick && guard < 600);
        if (!bus.tick) return;
        per = 0;
        do begin
            @(negedge clk); per++; guard++;
            highs += int'(bus.clk_div);
        end while (!bus.tick && guard < 1200);
        if (!bus.tick) per = -1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int g;
        g = 0;
        while (bus.busy && g < limit) begin @(negedge clk); g++; end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    logic [12:0] seq_a, seq_b;
    int per, highs, busy_n, tick_n, done_n, first_tick, last_tick, done_idx;

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_on = 1;
        check("reset_outputs", {26'd0, bus.clk_div, bus.tick, bus.busy, bus.done, bus.cfg_err, bus.cfg_ready}, 32'b000001);
        reset_n = 1'b1;

        // Default divisor 6 after start.
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        seq_a = '0; seq_b = '0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            seq_a = {seq_a[11:0], bus.clk_div};
            seq_b = {seq_b[11:0], bus.tick};
        end
        check("div6_clk_pattern", 32'(seq_a[11:0]), 32'b000111000111);
        check("div6_tick_pattern", 32'(seq_b[11:0]), 32'b000001000001);

        // Divisor 5 accepted at cnt 2 of a div-6 period.
        @(negedge clk); @(negedge clk); @(negedge clk);
        set_cfg(1, 5, 0, 4);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) bus.cfg_valid = 1'b0;
            seq_a = {seq_a[11:0], bus.clk_div};
            seq_b = {seq_b[11:0], bus.cfg_ready};
        end
        check("div5_switch_clk", 32'(seq_a), 32'b1110011100111);
        check("div5_switch_ready", 32'(seq_b), 32'b0001111111111);

        // Rejected configs.
        set_cfg(1, 1, 0, 4);
        @(negedge clk);
        check("err_div1", 32'(bus.cfg_err), 32'd1);
        set_cfg(1, 5, 1, 0);
        @(negedge clk);
        check("err_burst0", 32'(bus.cfg_err), 32'd1);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        check("err_one_cycle", 32'(bus.cfg_err), 32'd0);
        measure_period(per, highs);
        check("div_after_err", 32'(per), 32'd5);
        check("div5_high_cycles", 32'(highs), 32'd3);
        set_cfg(1, 6, 0, 4);
        @(negedge clk);
        check("good_cfg_taken", 32'(bus.cfg_ready), 32'd0);
        bus.cfg_valid = 1'b0;
        measure_period(per, highs);
        check("div6_after_good", 32'(per), 32'd6);

        bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0;
        wait_idle("stop_to_idle", 20);

        // Burst of 3 periods at divisor 4.
        set_cfg(1, 4, 1, 3);
        @(negedge clk); bus.cfg_valid = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        busy_n = 0; tick_n = 0; done_n = 0; first_tick = -1; last_tick = -1; done_idx = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            busy_n += int'(bus.busy);
            if (bus.tick) begin
                tick_n++; last_tick = i;
                if (first_tick < 0) first_tick = i;
            end
            if (bus.done) begin done_n++; done_idx = i; end
        end
        check("burst_busy_cycles", 32'(busy_n), 32'd12);
        check("burst_ticks", 32'(tick_n), 32'd3);
        check("burst_tick_span", 32'(last_tick - first_tick), 32'd8);
        check("burst_done_count", 32'(done_n), 32'd1);
        check("burst_done_after_tick", 32'(done_idx - last_tick), 32'd1);

        // Stop at cnt 1 of divisor 6.
        set_cfg(1, 6, 0, 4);
        @(negedge clk); bus.cfg_valid = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.stop = 1'b1;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus.stop = 1'b0;
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
        end
        check("stop_run_cycles", 32'(busy_n), 32'd4);
        check("stop_no_done", 32'(done_n), 32'd0);
        check("stop_clk_div_low", 32'(bus.clk_div), 32'd0);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.stop = 1'b0;
        check("stop_beats_start", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            busy_n += int'(bus.busy);
        end
        check("idle_stop_not_kept", 32'(busy_n), 32'd10);

        // Reset mid-burst with a pending config.
        set_cfg(1, 4, 1, 5);
        @(negedge clk); bus.cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        set_cfg(1, 9, 0, 4);
        @(negedge clk); bus.cfg_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", {26'd0, bus.clk_div, bus.tick, bus.busy, bus.done, bus.cfg_err, bus.cfg_ready}, 32'b000001);
        reset_n = 1'b1; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        measure_period(per, highs);
        check("post_reset_div", 32'(per), 32'd6);
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            done_n += int'(bus.done);
            busy_n += int'(bus.busy);
        end
        check("post_reset_continuous", 32'(busy_n), 32'd20);
        check("post_reset_no_done", 32'(done_n), 32'd0);

        // Largest divisor.
        set_cfg(1, 255, 0, 4);
        @(negedge clk); bus.cfg_valid = 1'b0;
        measure_period(per, highs);
        check("div255_period", 32'(per), 32'd255);
        check("div255_high_cycles", 32'(highs), 32'd128);
        bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0;
        wait_idle("div255_stop", 600);

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset_n   = ($urandom_range(0, 299) != 0);
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stop  = ($urandom_range(0, 23) == 0);
            r = int'($urandom_range(0, 31));
            set_cfg($urandom_range(0, 5) == 0,
                    (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 255 : int'($urandom_range(2, 9)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
            @(negedge clk);
        end
        reset_n = 1'b1;
        set_cfg(0, 0, 0, 0);
        bus.start = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
